// File: rtl/adc_decim_avg.sv
// adc_decim_avg -- block-average decimator for the unsigned ADC sample stream.
//
// Sums 2^R consecutive samples (R = ratio_log2, clamped to MAX_LOG2) and emits
// their mean as one word behind a valid/ready output register. The input side
// has no backpressure: a result that completes while the output register still
// holds an unaccepted word is dropped and the sticky overrun flag is raised.
//
// Optional feature macro: ADC_DECIM_ROUND_EN
//   defined   -> round-half-up mean, saturated to 2^WIDTH-1
//   undefined -> truncated mean (no rounding adder, no saturation)
//
// Ports:
//   clk         system clock (shared with the ADC capture block)
//   rst         synchronous, active-low reset
//   clear       synchronous, active-high soft clear (same effect as rst)
//   ratio_log2  decimation exponent R, sampled at reset/clear/block boundary
//   i_tdata     unsigned sample, WIDTH bits
//   i_tvalid    sample strobe
//   o_tdata     block mean, WIDTH bits (registered)
//   o_tvalid    result valid (registered)
//   o_tready    consumer accepts the result
//   overrun     sticky: a completed result was dropped
module adc_decim_avg #(
  parameter int WIDTH    = 14,
  parameter int MAX_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [3:0]       ratio_log2,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             overrun
);

  localparam int         ACC_W = WIDTH + MAX_LOG2;
  localparam logic [3:0] MAX_R = 4'(MAX_LOG2);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [3:0]          r_lat_q, r_lat_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic [3:0]          r_clamp_s;
  logic [MAX_LOG2-1:0] last_cnt_s;
  logic                last_s;
  logic [ACC_W-1:0]    sum_s;
  logic [WIDTH-1:0]    result_s;

  // Clamp the requested exponent to the accumulator's capacity.
  always_comb begin
    if (ratio_log2 > MAX_R) begin
      r_clamp_s = MAX_R;
    end else begin
      r_clamp_s = ratio_log2;
    end
  end

  // Block-end detection: counter value 2^r_lat - 1 is a mask of r_lat ones.
  always_comb begin
    last_cnt_s = {MAX_LOG2{1'b0}};
    for (int i = 0; i < MAX_LOG2; i++) begin
      last_cnt_s[i] = (i < int'(r_lat_q));
    end
    last_s = i_tvalid && (cnt_q == last_cnt_s);
    sum_s  = acc_q + {{MAX_LOG2{1'b0}}, i_tdata};
  end

`ifdef ADC_DECIM_ROUND_EN
  localparam int RW = ACC_W + 1;
  logic [RW-1:0] half_s, rsum_s, rshift_s;

  // Round-half-up mean; one extra bit keeps the rounding carry, then saturate.
  always_comb begin
    if (r_lat_q == 4'd0) begin
      half_s = {RW{1'b0}};
    end else begin
      half_s = {{(RW-1){1'b0}}, 1'b1} << (r_lat_q - 4'd1);
    end
    rsum_s   = {1'b0, sum_s} + half_s;
    rshift_s = rsum_s >> r_lat_q;
    if (|rshift_s[RW-1:WIDTH]) begin
      result_s = {WIDTH{1'b1}};
    end else begin
      result_s = rshift_s[WIDTH-1:0];
    end
  end
`else
  // Truncated mean: the sum always fits in WIDTH+r_lat bits, so the window is exact.
  always_comb begin
    result_s = sum_s[r_lat_q +: WIDTH];
  end
`endif

  // Next-state logic for the accumulator, counter, exponent and output register.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    r_lat_d = r_lat_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clear) begin
      // Soft clear discards any partial block and any pending/dropped result.
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = {MAX_LOG2{1'b0}};
      r_lat_d = r_clamp_s;
      data_d  = {WIDTH{1'b0}};
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (last_s) begin
        acc_d   = {ACC_W{1'b0}};
        cnt_d   = {MAX_LOG2{1'b0}};
        r_lat_d = r_clamp_s;
      end else if (i_tvalid) begin
        acc_d = sum_s;
        cnt_d = cnt_q + {{(MAX_LOG2-1){1'b0}}, 1'b1};
      end else begin
        acc_d = acc_q;
      end

      if (last_s) begin
        // Load only if the register is free this cycle; otherwise drop and flag.
        if (!valid_q || o_tready) begin
          data_d  = result_s;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else if (valid_q && o_tready) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {MAX_LOG2{1'b0}};
      r_lat_q <= r_clamp_s;
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      r_lat_q <= r_lat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_tdata  = data_q;
  assign o_tvalid = valid_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_adc_decim_avg.sv
// Self-checking bench for adc_decim_avg: directed scenarios followed by a
// randomized phase, all checked each cycle against a block-level reference
// model (sample queue per block, mean computed by integer division).
module tb_adc_decim_avg;

  localparam int WIDTH    = 14;
  localparam int MAX_LOG2 = 8;
  localparam int MAXV     = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             clear;
  logic [3:0]       ratio_log2;
  logic [WIDTH-1:0] i_tdata;
  logic             i_tvalid;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tvalid;
  logic             o_tready;
  logic             overrun;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int unsigned blk[$];
  int          m_r;
  int          m_data;
  bit          m_valid;
  bit          m_ovr;

  adc_decim_avg #(.WIDTH(WIDTH), .MAX_LOG2(MAX_LOG2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ratio_log2(ratio_log2),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampr(input int r);
    return (r > MAX_LOG2) ? MAX_LOG2 : r;
  endfunction

  // Mean of a completed block, from plain arithmetic.
  function automatic int block_mean(input longint sum, input int n);
    longint m;
`ifdef ADC_DECIM_ROUND_EN
    m = (2 * sum + n) / (2 * n);
    if (m > MAXV) m = MAXV;
`else
    m = sum / n;
`endif
    return int'(m);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    longint sum;
    int     res;
    bit     newres;
    if (!rst || clear) begin
      blk.delete();
      m_r = clampr(int'(ratio_log2));
      m_data = 0; m_valid = 0; m_ovr = 0;
    end else begin
      newres = 0;
      res = 0;
      if (i_tvalid) begin
        blk.push_back(int'(i_tdata));
        if (blk.size() == (1 << m_r)) begin
          sum = 0;
          foreach (blk[k]) sum += blk[k];
          res = block_mean(sum, 1 << m_r);
          blk.delete();
          m_r = clampr(int'(ratio_log2));
          newres = 1;
        end
      end
      if (newres) begin
        if (!m_valid || o_tready) begin
          m_data = res; m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && o_tready) begin
        m_valid = 0;
      end
    end
  endtask

  // One clock: inputs already applied at negedge; compare at next negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("o_tvalid", int'(o_tvalid), int'(m_valid));
    chk("o_tdata", int'(o_tdata), m_data);
    chk("overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic beat(input int d);
    i_tvalid = 1'b1;
    i_tdata  = WIDTH'(d);
    cycle();
    i_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_clear(input int r);
    ratio_log2 = 4'(r);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    int expect2;
    rst = 1'b0; clear = 1'b0; ratio_log2 = 4'd0;
    i_tdata = '0; i_tvalid = 1'b0; o_tready = 1'b1;
    m_r = 0; m_data = 0; m_valid = 0; m_ovr = 0;
    @(negedge clk);
    cycle(); cycle();
    chk("reset_tvalid", int'(o_tvalid), 0);
    chk("reset_tdata", int'(o_tdata), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b1;

    // R=0 pass-through, one clock after each beat
    beat(100);   chk("r0_100", int'(o_tdata), 100);
    beat(2000);  chk("r0_2000", int'(o_tdata), 2000);
    beat(16383); chk("r0_16383", int'(o_tdata), 16383);
    chk("r0_overrun", int'(overrun), 0);
    idle(2);

    // R=2, samples 1,2,3,5
    do_clear(2);
    beat(1); beat(2); beat(3); beat(5);
`ifdef ADC_DECIM_ROUND_EN
    expect2 = 3;
`else
    expect2 = 2;
`endif
    chk("r2_valid", int'(o_tvalid), 1);
    chk("r2_mean", int'(o_tdata), expect2);
    idle(2);

    // R clamped to 8: 256 full-scale samples, no wrap
    do_clear(15);
    for (int k = 0; k < 256; k++) beat(16383);
    chk("r8_fullscale", int'(o_tdata), 16383);
    idle(2);

    // R=1 with stalled consumer: second result dropped
    do_clear(1);
    o_tready = 1'b0;
    beat(10); beat(20); beat(10); beat(20);
    chk("ovr_data", int'(o_tdata), 15);
    chk("ovr_flag", int'(overrun), 1);
    o_tready = 1'b1;
    idle(1);
    chk("ovr_accept", int'(o_tvalid), 0);
    do_clear(1);
    chk("ovr_cleared", int'(overrun), 0);

    // Ratio change mid-block only applies at the block boundary
    do_clear(2);
    beat(4); beat(8);
    ratio_log2 = 4'd0;
    beat(12);
    chk("rchg_midblock", int'(o_tvalid), 0);
    beat(16);
    chk("rchg_blockmean", int'(o_tdata), 10);
    beat(77);  chk("rchg_pass1", int'(o_tdata), 77);
    beat(300); chk("rchg_pass2", int'(o_tdata), 300);
    idle(2);

    // Reset mid-block discards partial sum
    do_clear(3);
    for (int k = 0; k < 5; k++) beat(9000);
    rst = 1'b0;
    cycle();
    chk("rst_mid_valid", int'(o_tvalid), 0);
    chk("rst_mid_data", int'(o_tdata), 0);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) beat(40);
    chk("rst_mid_mean", int'(o_tdata), 40);
    idle(2);

    // Randomized traffic, ratio changes, clears and resets
    for (int k = 0; k < 6000; k++) begin
      if ((k % 400) == 0) ratio_log2 = 4'($urandom_range(15, 0));
      i_tvalid = ($urandom_range(3, 0) != 0);
      i_tdata  = WIDTH'($urandom_range(MAXV, 0));
      o_tready = ($urandom_range(2, 0) != 0);
      clear    = ($urandom_range(299, 0) == 0);
      rst      = ($urandom_range(999, 0) != 0);
      cycle();
    end
    rst = 1'b1; clear = 1'b0; i_tvalid = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
